// File: rtl/axi_rd_responder_pkg.sv
// Shared types and encodings for the AXI4 read responder and its address generator.
package axi_rd_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {IDLE, WAIT, READ, RESP} state_t;

   typedef logic [7:0] burst_len_t;
   typedef logic [3:0] axi_id_t;

   function automatic logic wrap_len_ok(input burst_len_t len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_rd_responder_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts plus per-beat legality flags.
module axi_burst_addr_gen
   import axi_rd_responder_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        size,
   input  burst_len_t        len,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr,
   output logic              misaligned,
   output logic              illegal
);

   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] container;
   logic [ADDR_W-1:0] mask;
   logic              bad_burst;

   always_comb begin
      step       = ADDR_W'(1) << size;
      container  = step * ADDR_W'(len) + step;
      mask       = container - ADDR_W'(1);
      bad_burst  = (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
      illegal    = bad_burst || (size > 3'd3);
      misaligned = (addr & (step - ADDR_W'(1))) != '0;
      // An unusable burst type has no defined address sequence, so it stays put like FIXED.
      next_addr  = addr;
      if (!bad_burst) begin
         case (burst)
            BURST_INCR: next_addr = addr + step;
            BURST_WRAP: next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:    next_addr = addr;
         endcase
      end
   end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel slave: one burst at a time served from a synchronous single-port memory.
//  state | meaning
//  IDLE  | s_arready high, waiting for an AR handshake
//  WAIT  | first-beat latency countdown
//  READ  | one-cycle memory read of the current beat (suppressed on error)
//  RESP  | s_rvalid high, beat held until s_rready
module axi_rd_responder
   import axi_rd_responder_pkg::*;
#(
   parameter int                ADDR_W = 32,
   parameter int                DATA_W = 64,
   parameter int                MEM_AW = 16,
   parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] SIZE   = 32'h0800_0000,
   parameter int                LAT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_arvalid,
   output logic              s_arready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  axi_id_t           s_arid,
   input  burst_len_t        s_arlen,
   input  logic [2:0]        s_arsize,
   input  logic [1:0]        s_arburst,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rlast,
   output axi_id_t           s_rid,
   output logic              mem_ren,
   output logic [MEM_AW-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, next_addr, offset;
   axi_id_t           id_q, rid_q;
   burst_len_t        len_q, beat_q;
   logic [2:0]        size_q;
   logic [1:0]        burst_q, rresp_q;
   logic [7:0]        lat_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rlast_q, fresh_q;
   logic              misaligned, illegal, in_range, beat_decerr, beat_slverr;

   axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .addr       (addr_q),
      .size       (size_q),
      .len        (len_q),
      .burst      (burst_q),
      .next_addr  (next_addr),
      .misaligned (misaligned),
      .illegal    (illegal)
   );

   always_comb begin
      offset      = addr_q - BASE;
      in_range    = ({1'b0, addr_q} >= {1'b0, BASE}) &&
                    ({1'b0, addr_q} < ({1'b0, BASE} + {1'b0, SIZE}));
      beat_decerr = !in_range;
      beat_slverr = misaligned || illegal;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (s_arvalid) state_d = (LAT == 0) ? READ : WAIT;
         WAIT:    if (lat_q == 8'd1) state_d = READ;
         READ:    state_d = RESP;
         RESP:    if (s_rready) state_d = rlast_q ? IDLE : READ;
         default: state_d = IDLE;
      endcase
   end

   // Memory data arrives in the first RESP cycle, so it is passed through then and held from rdata_q after.
   always_comb begin
      s_arready = (state_q == IDLE);
      s_rvalid  = (state_q == RESP);
      mem_ren   = (state_q == READ) && !beat_decerr && !beat_slverr;
      mem_raddr = MEM_AW'(offset >> 3);
      s_rdata   = fresh_q ? ((rresp_q == RESP_OKAY) ? mem_rdata : '0) : rdata_q;
      s_rresp   = rresp_q;
      s_rlast   = rlast_q;
      s_rid     = rid_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         id_q    <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         lat_q   <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
         rid_q   <= '0;
         fresh_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fresh_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s_arvalid) begin
                  addr_q  <= s_araddr;
                  id_q    <= s_arid;
                  len_q   <= s_arlen;
                  size_q  <= s_arsize;
                  burst_q <= s_arburst;
                  beat_q  <= '0;
                  lat_q   <= 8'(LAT);
               end
            end
            WAIT: lat_q <= lat_q - 8'd1;
            READ: begin
               rresp_q <= beat_decerr ? RESP_DECERR : (beat_slverr ? RESP_SLVERR : RESP_OKAY);
               rlast_q <= (beat_q == len_q);
               rid_q   <= id_q;
               fresh_q <= 1'b1;
            end
            RESP: begin
               if (fresh_q) rdata_q <= s_rdata;
               if (s_rready && !rlast_q) begin
                  beat_q <= beat_q + 8'd1;
                  addr_q <= next_addr;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
AXI4 read-channel slave that answers AR/R transactions from the arbiter's downstream port. It is the responder-side counterpart of the fetch and load initiators. It serves FIXED, INCR and WRAP bursts out of a synchronous single-port backing memory, with programmable first-beat latency, address-range checking and ID echo. Instantiated in the simulation SoC and on-chip SRAM wrapper; one burst outstanding at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data bus width (bytes per beat = DATA_W/8)
MEM_AW, 16, backing memory word-address width
BASE, 32'h8000_0000, first legal byte address
SIZE, 32'h0800_0000, legal window size in bytes (END = BASE+SIZE, exclusive)
LAT, 2, idle cycles between AR accept and first memory read (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_araddr  in  ADDR_W  byte address
s_arid  in  4  transaction id
s_arlen  in  8  beats-1
s_arsize  in  3  log2 bytes per beat
s_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rdata  out  DATA_W  read data
s_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_rlast  out  1  final beat
s_rid  out  4  echoed id
mem_ren  out  1  memory read strobe
mem_raddr  out  MEM_AW  word address ((addr-BASE)>>3)
mem_rdata  in  DATA_W  valid the cycle after mem_ren

Behaviour:
- Reset (rst==0 at posedge): state IDLE; s_arready=1; s_rvalid=0; s_rlast=0; s_rdata=0; s_rresp=00; s_rid=0; mem_ren=0. Reset mid-burst abandons the burst and produces no further beats.
- States: IDLE, WAIT, READ, RESP.
- IDLE: s_arready=1. On arvalid&arready, latch addr, id, len, size, burst; beat counter=0; latency counter=LAT; s_arready<=0. Go to WAIT, or READ if LAT==0.
- WAIT: decrement the counter each cycle; at 1 go to READ. s_arready stays 0.
- READ: for one cycle, mem_ren=1 and mem_raddr=beat address. If the beat is in error, mem_ren=0. Next state RESP; s_rdata, s_rresp, s_rlast and s_rid are registered from mem_rdata at the RESP entry edge.
- RESP: s_rvalid=1. While rready=0, rdata, rresp, rlast and rid are held stable. On handshake, s_rvalid<=0.
  - If rlast: go to IDLE, s_arready<=1.
  - Otherwise: beat counter+1, advance address, go to READ (no repeated latency).
- Throughput: 1 beat per 2 cycles after the first. AR is never accepted while a burst is in flight.
- Address advance, with step = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+step.
  - WRAP: container = step*(len+1); low bits wrap inside the container-aligned boundary.
- Error per beat:
  - Address outside [BASE, END): DECERR, rdata=0.
  - Address misaligned to size, size>3, burst==11, or WRAP with len not in {1,3,7,15}: SLVERR, rdata=0.
  - Errors never stop the burst; exactly len+1 beats are always returned.
- rlast=1 exactly when beat counter == latched len.
- Sub-word sizes return the full aligned 64-bit word; the initiator selects the lane (e.g. the fetch unit picks the addr[2] half).
- Initiator deasserting arvalid before the handshake: nothing is latched.

Decomposition:
- Shared package: RESP_OKAY/SLVERR/DECERR, BURST_FIXED/INCR/WRAP, state enum {IDLE, WAIT, READ, RESP}, burst_len_t, axi_id_t.
- One natural sub-module: axi_burst_addr_gen, a combinational next-address function of addr, size, len and burst that also produces the misaligned/illegal flags.

Test Plan:
- Single beat: araddr=8000_0008, len=0, size=3, INCR, id=5, LAT=2, memory word 1 = DEAD_BEEF_CAFE_F00D -> rvalid 4 cycles after AR handshake, rdata=DEAD_BEEF_CAFE_F00D, rresp=00, rlast=1, rid=5, arready high the cycle after R handshake.
- INCR burst of 4: addr=8000_0000, len=3, rready always 1 -> mem_raddr 0,1,2,3; rlast only on 4th beat; beats 2 cycles apart.
- WRAP: addr=8000_0010, len=3, size=3 -> mem_raddr 2,3,0,1.
- Backpressure: rready=0 for 5 cycles in beat 2 -> rvalid, rdata and rlast stable throughout; no mem_ren while stalled; burst completes with correct data.
- Errors: addr=7FFF_FFF8 len=0 -> rresp=11, rdata=0; addr=8000_0004 size=3 -> rresp=10; INCR crossing END on beat 2 of 2 -> beat1 00, beat2 11, rlast on beat2.
- Reset mid-burst: rst=0 during RESP of beat 2 of 4 -> next cycle rvalid=0, arready=1; a new AR then completes normally with a fresh rid.
